// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO between the memory stage and data memory
// Drains one store per cycle when the port is free and forwards the youngest match to loads.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              mem_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              ovf_err
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;

  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_scan_idx;

  // Ready comes from registered count only, so a pop while full does not free a slot this cycle.
  assign st_ready  = (r_count != CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign ovf_err   = r_ovf;
  assign mem_we    = !empty && !mem_busy;
  assign mem_addr  = r_addr[r_rd_ptr];
  assign mem_wdata = r_data[r_rd_ptr];
  assign w_push    = st_valid && st_ready;
  assign w_pop     = mem_we;

  // Scan oldest to youngest from the tail; the last hit wins, giving the youngest match.
  always_comb begin
    fwd_hit    = 1'b0;
    fwd_data   = '0;
    w_scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_scan_idx = r_rd_ptr + PTR_W'(i);
      if (r_valid[w_scan_idx] && (r_addr[w_scan_idx] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_data[w_scan_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_addr[r_wr_ptr] <= st_addr;
      r_data[r_wr_ptr] <= st_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (st_valid && !st_ready) begin
        r_ovf <= 1'b1;
      end
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard and vector-table bench for store_buffer
module tb_store_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;
  logic              mem_busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] ld_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              ovf_err;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count), .empty(empty), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t m_q[$];
  logic   m_ovf;
  bit     m_chk_en;
  int     m_writes;
  int     total;
  int     bad;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT against the queue model, then advance the model to the coming edge.
  task automatic check_cycle();
    bit     exp_ready;
    bit     exp_we;
    bit     exp_hit;
    entry_t e;
    logic [DATA_W-1:0] exp_fwd;
    exp_ready = (m_q.size() != DEPTH);
    exp_we    = (m_q.size() != 0) && !mem_busy;
    exp_hit   = 1'b0;
    exp_fwd   = '0;
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (!exp_hit && m_q[i].addr == ld_addr) begin
        exp_hit = 1'b1;
        exp_fwd = m_q[i].data;
      end
    end
    if (m_chk_en) begin
      cmp("st_ready", st_ready, exp_ready);
      cmp("count", count, m_q.size());
      cmp("empty", empty, m_q.size() == 0);
      cmp("ovf_err", ovf_err, m_ovf);
      cmp("mem_we", mem_we, exp_we);
      if (exp_we && mem_we) begin
        cmp("mem_addr", mem_addr, m_q[0].addr);
        cmp("mem_wdata", mem_wdata, m_q[0].data);
      end
      cmp("fwd_hit", fwd_hit, exp_hit);
      if (exp_hit) cmp("fwd_data", fwd_data, exp_fwd);
    end
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (exp_we) begin
        void'(m_q.pop_front());
        m_writes++;
      end
      if (st_valid) begin
        if (exp_ready) begin
          e.addr = st_addr;
          e.data = st_data;
          m_q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic              v;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              busy;
    logic [ADDR_W-1:0] ld;
    logic [CNT_W-1:0]  e_count;
    logic              e_we;
    logic              e_hit;
    logic              e_chk_data;
    logic [DATA_W-1:0] e_data;
  } vec_t;

  vec_t vecs[10];
  int   w0;

  initial begin
    total = 0; bad = 0; m_writes = 0; m_ovf = 1'b0; m_chk_en = 1'b0;
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; mem_busy = 1'b1; ld_addr = '0;

    vecs[0] = '{1'b1, 10'h020, 32'h11, 1'b1, 10'h020, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 10'h021, 32'h22, 1'b1, 10'h020, 3'd1, 1'b0, 1'b1, 1'b1, 32'h11};
    vecs[2] = '{1'b1, 10'h020, 32'h33, 1'b1, 10'h020, 3'd2, 1'b0, 1'b1, 1'b1, 32'h11};
    vecs[3] = '{1'b0, 10'h000, 32'h0,  1'b1, 10'h020, 3'd3, 1'b0, 1'b1, 1'b1, 32'h33};
    vecs[4] = '{1'b0, 10'h000, 32'h0,  1'b1, 10'h021, 3'd3, 1'b0, 1'b1, 1'b1, 32'h22};
    vecs[5] = '{1'b0, 10'h000, 32'h0,  1'b1, 10'h030, 3'd3, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 10'h000, 32'h0,  1'b0, 10'h020, 3'd3, 1'b1, 1'b1, 1'b1, 32'h33};
    vecs[7] = '{1'b0, 10'h000, 32'h0,  1'b0, 10'h020, 3'd2, 1'b1, 1'b1, 1'b1, 32'h33};
    vecs[8] = '{1'b0, 10'h000, 32'h0,  1'b0, 10'h020, 3'd1, 1'b1, 1'b1, 1'b1, 32'h33};
    vecs[9] = '{1'b0, 10'h000, 32'h0,  1'b0, 10'h020, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0};

    step(); step();
    rst = 1'b0; mem_busy = 1'b0; m_chk_en = 1'b1;

    // Reset then idle
    @(negedge clk);
    cmp("rst_st_ready", st_ready, 1'b1);
    cmp("rst_empty", empty, 1'b1);
    cmp("rst_count", count, 0);
    cmp("rst_mem_we", mem_we, 1'b0);
    cmp("rst_fwd_hit", fwd_hit, 1'b0);
    cmp("rst_ovf_err", ovf_err, 1'b0);
    @(posedge clk); #1;
    step();

    // Single store drains in the following cycle
    st_valid = 1'b1; st_addr = 10'h010; st_data = 32'hDEADBEEF;
    step();
    st_valid = 1'b0;
    @(negedge clk);
    cmp("single_we", mem_we, 1'b1);
    cmp("single_addr", mem_addr, 32'h010);
    cmp("single_data", mem_wdata, 32'hDEADBEEF);
    check_cycle();
    @(posedge clk); #1;
    @(negedge clk);
    cmp("single_empty_after", empty, 1'b1);
    @(posedge clk); #1;

    // Forwarding table, then draining while the head still forwards
    for (int i = 0; i < 10; i++) begin
      st_valid = vecs[i].v; st_addr = vecs[i].a; st_data = vecs[i].d;
      mem_busy = vecs[i].busy; ld_addr = vecs[i].ld;
      @(negedge clk);
      cmp($sformatf("vec%0d_count", i), count, vecs[i].e_count);
      cmp($sformatf("vec%0d_we", i), mem_we, vecs[i].e_we);
      cmp($sformatf("vec%0d_hit", i), fwd_hit, vecs[i].e_hit);
      if (vecs[i].e_chk_data) cmp($sformatf("vec%0d_fwd", i), fwd_data, vecs[i].e_data);
      check_cycle();
      @(posedge clk); #1;
    end
    st_valid = 1'b0; ld_addr = 10'h3FF;

    // Overflow: stall drain, push five, fifth dropped
    mem_busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      st_valid = 1'b1; st_addr = ADDR_W'(i); st_data = 32'hA000 + 32'(i);
      step();
    end
    st_valid = 1'b0;
    @(negedge clk);
    cmp("ovf_count_full", count, 4);
    cmp("ovf_not_ready", st_ready, 1'b0);
    cmp("ovf_sticky", ovf_err, 1'b1);
    @(posedge clk); #1;
    mem_busy = 1'b0;
    w0 = m_writes;
    for (int i = 0; i < 5; i++) step();
    cmp("ovf_drain_writes", m_writes - w0, 4);
    cmp("ovf_drained_empty", empty, 1'b1);

    // Full buffer with st_valid held: pop each cycle, wrap the pointers
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_addr = 10'h100 + ADDR_W'(i); st_data = 32'hB000 + 32'(i);
      step();
    end
    mem_busy = 1'b0;
    w0 = m_writes;
    for (int i = 4; i < 16; i++) begin
      st_valid = 1'b1; st_addr = 10'h100 + ADDR_W'(i); st_data = 32'hB000 + 32'(i);
      ld_addr = 10'h100 + ADDR_W'(i - 1);
      step();
    end
    st_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    cmp("full_all_drained", empty, 1'b1);
    cmp("full_write_count", (m_writes - w0) > 4, 1'b1);

    // Reset discards three pending entries
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 10'h200 + ADDR_W'(i); st_data = 32'hC000 + 32'(i);
      step();
    end
    st_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; mem_busy = 1'b0;
    @(negedge clk);
    cmp("rst3_count", count, 0);
    cmp("rst3_empty", empty, 1'b1);
    cmp("rst3_we", mem_we, 1'b0);
    cmp("rst3_ovf", ovf_err, 1'b0);
    @(posedge clk); #1;
    w0 = m_writes;
    for (int i = 0; i < 4; i++) step();
    cmp("rst3_no_writes", m_writes - w0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
